// File: rtl/fpu_pkg.sv
// Shared floating-point issue definitions: opcodes, quiet-NaN constant and
// the in-flight tag carried alongside each operation.
package fpu_pkg;

  localparam logic [2:0]  OP_ADD = 3'b000;
  localparam logic [2:0]  OP_SUB = 3'b001;
  localparam logic [2:0]  OP_NOP = 3'b111;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;

  // One in-flight operation: who issued it and whether the ALU can execute it.
  typedef struct packed {
    logic valid;
    logic id;
    logic unsup;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  // The attached pipeline only implements add and subtract.
  function automatic logic is_supported(input logic [2:0] ctrl);
    return (ctrl == OP_ADD) || (ctrl == OP_SUB);
  endfunction

endpackage

// File: rtl/fpu_issue_arb_if.sv
// Bus bundle for the issue arbiter: two request ports, the ALU operand/result
// path and two response ports.
//
// Handshake: a transfer happens on a rising FPUCLK edge where VALID and READY
// are both high. A requester holds VALID and its payload stable until the
// transfer; READY may be computed combinationally from the current cycle.
interface fpu_issue_arb_if;
  logic        REQ0_VALID, REQ1_VALID;
  logic        REQ0_READY, REQ1_READY;
  logic [31:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic [2:0]  REQ0_CTRL, REQ1_CTRL;
  logic [31:0] ALU_A, ALU_B;
  logic [2:0]  ALU_CTRL;
  logic [31:0] ALU_OUT;
  logic        RSP0_VALID, RSP1_VALID;
  logic        RSP0_READY, RSP1_READY;
  logic [31:0] RSP0_DATA, RSP1_DATA;

  // Requesters, ALU and response consumers.
  modport master (
    output REQ0_VALID, REQ1_VALID, REQ0_A, REQ0_B, REQ1_A, REQ1_B,
           REQ0_CTRL, REQ1_CTRL, ALU_OUT, RSP0_READY, RSP1_READY,
    input  REQ0_READY, REQ1_READY, ALU_A, ALU_B, ALU_CTRL,
           RSP0_VALID, RSP1_VALID, RSP0_DATA, RSP1_DATA
  );

  // The arbiter itself.
  modport slave (
    input  REQ0_VALID, REQ1_VALID, REQ0_A, REQ0_B, REQ1_A, REQ1_B,
           REQ0_CTRL, REQ1_CTRL, ALU_OUT, RSP0_READY, RSP1_READY,
    output REQ0_READY, REQ1_READY, ALU_A, ALU_B, ALU_CTRL,
           RSP0_VALID, RSP1_VALID, RSP0_DATA, RSP1_DATA
  );
endinterface

// File: rtl/fpu_rsp_fifo.sv
// Small synchronous response FIFO. Head is presented combinationally;
// a push and a pop on the same edge are both performed.
module fpu_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] data
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid   = (count != '0);
  assign data    = mem[rd_ptr];
  assign do_pop  = pop & valid;
  // Upstream credits keep a push off a full FIFO; the guard only protects state.
  assign do_push = push & ((count != CW'(DEPTH)) | do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push & ~do_pop)      count <= count + CW'(1);
      else if (~do_push & do_pop) count <= count - CW'(1);
    end
  end

  // Storage, cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/fpu_issue_arb.sv
// Two-port round-robin issue arbiter for the non-stalling FP add/sub pipeline.
// Credits (one per response FIFO slot) gate issue so results always have a
// home; a tag shift register routes each result back to its requester.
// Optional statistics counters are enabled with FPU_ARB_STATS_EN.
module fpu_issue_arb
  import fpu_pkg::*;
#(
  parameter int LAT       = 4,
  parameter int RSP_DEPTH = 2
) (
  input  logic FPUCLK,
  input  logic RSTN,
  fpu_issue_arb_if.slave bus
`ifdef FPU_ARB_STATS_EN
  ,
  output logic [15:0] ISSUE_CNT,
  output logic [15:0] STALL_CNT
`endif
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] CREDIT_INIT = CW'(RSP_DEPTH);

  logic [CW-1:0] credit0, credit1;
  logic          last_gnt;
  logic          elig0, elig1, gnt0, gnt1, accept;
  logic          rsp0_valid, rsp1_valid, pop0, pop1;
  logic [31:0]   sel_a, sel_b;
  logic [2:0]    sel_ctrl;
  logic          sel_unsup;
  tag_t          tag_pipe [LAT+1];
  tag_t          tag_in, tag_out;
  logic          push0, push1;
  logic [31:0]   push_data;

  // Eligibility and round-robin grant; nothing is granted while in reset.
  always_comb begin
    elig0 = RSTN & bus.REQ0_VALID & (credit0 != '0);
    elig1 = RSTN & bus.REQ1_VALID & (credit1 != '0);
    gnt0  = elig0 & (~elig1 | last_gnt);
    gnt1  = elig1 & (~elig0 | ~last_gnt);
  end

  assign accept         = gnt0 | gnt1;
  assign bus.REQ0_READY = gnt0;
  assign bus.REQ1_READY = gnt1;
  assign pop0           = rsp0_valid & bus.RSP0_READY;
  assign pop1           = rsp1_valid & bus.RSP1_READY;

  // Payload of the granted requester and the tag it will carry.
  always_comb begin
    sel_a     = gnt1 ? bus.REQ1_A    : bus.REQ0_A;
    sel_b     = gnt1 ? bus.REQ1_B    : bus.REQ0_B;
    sel_ctrl  = gnt1 ? bus.REQ1_CTRL : bus.REQ0_CTRL;
    sel_unsup = ~is_supported(sel_ctrl);
    tag_in    = '0;
    if (accept) tag_in = '{valid: 1'b1, id: gnt1, unsup: sel_unsup};
  end

  // Credits and last-grant pointer; accept and pop in one cycle cancel out.
  always_ff @(posedge FPUCLK or negedge RSTN) begin
    if (!RSTN) begin
      credit0  <= CREDIT_INIT;
      credit1  <= CREDIT_INIT;
      last_gnt <= 1'b1;
    end else begin
      if (gnt0 & ~pop0)      credit0 <= credit0 - CW'(1);
      else if (~gnt0 & pop0) credit0 <= credit0 + CW'(1);
      if (gnt1 & ~pop1)      credit1 <= credit1 - CW'(1);
      else if (~gnt1 & pop1) credit1 <= credit1 + CW'(1);
      if (accept) last_gnt <= gnt1;
    end
  end

  // Issue register: operands hold between issues, opcode idles at NOP.
  always_ff @(posedge FPUCLK or negedge RSTN) begin
    if (!RSTN) begin
      bus.ALU_A    <= '0;
      bus.ALU_B    <= '0;
      bus.ALU_CTRL <= OP_NOP;
    end else if (accept) begin
      bus.ALU_A    <= sel_a;
      bus.ALU_B    <= sel_b;
      bus.ALU_CTRL <= sel_unsup ? OP_NOP : sel_ctrl;
    end else begin
      bus.ALU_CTRL <= OP_NOP;
    end
  end

  // Tag pipe shifts every cycle, matching the ALU which never stalls.
  always_ff @(posedge FPUCLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i <= LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i <= LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tag_out   = tag_pipe[LAT];
  assign push0     = tag_out.valid & ~tag_out.id;
  assign push1     = tag_out.valid &  tag_out.id;
  assign push_data = tag_out.unsup ? QNAN : bus.ALU_OUT;

  fpu_rsp_fifo #(.DEPTH(RSP_DEPTH), .W(32)) u_rsp_fifo0 (
    .clk       (FPUCLK),
    .rst_n     (RSTN),
    .push      (push0),
    .push_data (push_data),
    .pop       (bus.RSP0_READY),
    .valid     (rsp0_valid),
    .data      (bus.RSP0_DATA)
  );

  fpu_rsp_fifo #(.DEPTH(RSP_DEPTH), .W(32)) u_rsp_fifo1 (
    .clk       (FPUCLK),
    .rst_n     (RSTN),
    .push      (push1),
    .push_data (push_data),
    .pop       (bus.RSP1_READY),
    .valid     (rsp1_valid),
    .data      (bus.RSP1_DATA)
  );

  assign bus.RSP0_VALID = rsp0_valid;
  assign bus.RSP1_VALID = rsp1_valid;

`ifdef FPU_ARB_STATS_EN
  // Saturating issue and stall counters.
  always_ff @(posedge FPUCLK or negedge RSTN) begin
    if (!RSTN) begin
      ISSUE_CNT <= '0;
      STALL_CNT <= '0;
    end else begin
      if (accept && ISSUE_CNT != 16'hFFFF) ISSUE_CNT <= ISSUE_CNT + 16'd1;
      if ((bus.REQ0_VALID | bus.REQ1_VALID) && !accept && STALL_CNT != 16'hFFFF)
        STALL_CNT <= STALL_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_issue_arb.sv
// Bench for fpu_issue_arb: a behavioural ALU stub, a driver, and a monitor
// that predicts grants, issue-register contents and responses from the
// credit/round-robin rules using per-requester queues of outstanding ops.
module tb_fpu_issue_arb;
  import fpu_pkg::*;

  localparam int LAT       = 4;
  localparam int RSP_DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic FPUCLK = 1'b0;
  logic RSTN   = 1'b0;
  always #5 FPUCLK = ~FPUCLK;

  int cyc = 0;
  always @(posedge FPUCLK) cyc <= cyc + 1;

  fpu_issue_arb_if bus ();

`ifdef FPU_ARB_STATS_EN
  logic [15:0] issue_cnt, stall_cnt;
`endif

  fpu_issue_arb #(.LAT(LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
    .FPUCLK (FPUCLK),
    .RSTN   (RSTN),
    .bus    (bus)
`ifdef FPU_ARB_STATS_EN
    ,
    .ISSUE_CNT (issue_cnt),
    .STALL_CNT (stall_cnt)
`endif
  );

  // ---------------- ALU stub ----------------
  // Arbitrary but operand-sensitive function standing in for the FP adder.
  function automatic logic [31:0] alu_func(input logic [31:0] a, b, input logic [2:0] c);
    if (c == OP_NOP) return 32'hFFFF_0000;
    return (a ^ {b[15:0], b[31:16]}) + {29'd0, c};
  endfunction

  logic [31:0] alu_pipe [LAT];
  always @(posedge FPUCLK) begin
    alu_pipe[0] <= alu_func(bus.ALU_A, bus.ALU_B, bus.ALU_CTRL);
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign bus.ALU_OUT = alu_pipe[LAT-1];

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q0[$], exp_q1[$];
  int          stamp_q0[$], stamp_q1[$];
  logic        last_m;
  logic [2:0]  exp_ctrl;
  logic [31:0] exp_a, exp_b;
  int          issue_m, stall_m;
  int          acc0_total = 0, acc1_total = 0;

  // Driver-to-monitor report channel for checks the driver sets up.
  string       rep_name;
  logic [31:0] rep_got, rep_exp;
  int          rep_seq  = 0;
  int          rep_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / reference model ----------------
  int          cr0, cr1;
  logic        el0, el1, g0, g1, ev0, ev1, unsup;
  logic [31:0] sa, sb, res;
  logic [2:0]  sc;

  always @(negedge FPUCLK) begin
    if (rep_seq != rep_seen) begin
      chk(rep_name, rep_got, rep_exp);
      rep_seen = rep_seq;
    end
    if (!RSTN) begin
      chk("rst_req0_ready", bus.REQ0_READY, 0);
      chk("rst_req1_ready", bus.REQ1_READY, 0);
      chk("rst_alu_ctrl",   bus.ALU_CTRL, OP_NOP);
      chk("rst_alu_a",      bus.ALU_A, 0);
      chk("rst_alu_b",      bus.ALU_B, 0);
      chk("rst_rsp0_valid", bus.RSP0_VALID, 0);
      chk("rst_rsp1_valid", bus.RSP1_VALID, 0);
      chk("rst_rsp0_data",  bus.RSP0_DATA, 0);
      chk("rst_rsp1_data",  bus.RSP1_DATA, 0);
`ifdef FPU_ARB_STATS_EN
      chk("rst_issue_cnt", issue_cnt, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
`endif
      exp_q0.delete(); exp_q1.delete();
      stamp_q0.delete(); stamp_q1.delete();
      last_m   = 1'b1;
      exp_ctrl = OP_NOP;
      exp_a    = '0;
      exp_b    = '0;
      issue_m  = 0;
      stall_m  = 0;
    end else begin
      chk("alu_ctrl", bus.ALU_CTRL, exp_ctrl);
      chk("alu_a", bus.ALU_A, exp_a);
      chk("alu_b", bus.ALU_B, exp_b);
`ifdef FPU_ARB_STATS_EN
      chk("issue_cnt", issue_cnt, issue_m[15:0]);
      chk("stall_cnt", stall_cnt, stall_m[15:0]);
`endif
      // Grant prediction: credits are slots not yet claimed by outstanding ops.
      cr0 = RSP_DEPTH - exp_q0.size();
      cr1 = RSP_DEPTH - exp_q1.size();
      el0 = bus.REQ0_VALID && (cr0 > 0);
      el1 = bus.REQ1_VALID && (cr1 > 0);
      g0  = el0 && (!el1 || last_m == 1'b1);
      g1  = el1 && (!el0 || last_m == 1'b0);
      chk("req0_ready", bus.REQ0_READY, g0);
      chk("req1_ready", bus.REQ1_READY, g1);
      if (bus.REQ0_VALID && bus.REQ0_READY) acc0_total++;
      if (bus.REQ1_VALID && bus.REQ1_READY) acc1_total++;

      if (g0 || g1) begin
        sa    = g1 ? bus.REQ1_A    : bus.REQ0_A;
        sb    = g1 ? bus.REQ1_B    : bus.REQ0_B;
        sc    = g1 ? bus.REQ1_CTRL : bus.REQ0_CTRL;
        unsup = !(sc == OP_ADD || sc == OP_SUB);
        res   = unsup ? QNAN : alu_func(sa, sb, sc);
        if (g1) begin exp_q1.push_back(res); stamp_q1.push_back(cyc + 1); end
        else    begin exp_q0.push_back(res); stamp_q0.push_back(cyc + 1); end
        exp_ctrl = unsup ? OP_NOP : sc;
        exp_a    = sa;
        exp_b    = sb;
        last_m   = g1;
        issue_m++;
      end else begin
        exp_ctrl = OP_NOP;
        if (bus.REQ0_VALID || bus.REQ1_VALID) stall_m++;
      end

      // A result is visible LAT+1 edges after its accept edge.
      ev0 = (exp_q0.size() > 0) && (stamp_q0[0] + LAT + 1 <= cyc);
      ev1 = (exp_q1.size() > 0) && (stamp_q1[0] + LAT + 1 <= cyc);
      chk("rsp0_valid", bus.RSP0_VALID, ev0);
      chk("rsp1_valid", bus.RSP1_VALID, ev1);
      if (ev0) begin
        chk("rsp0_data", bus.RSP0_DATA, exp_q0[0]);
        if (bus.RSP0_READY) begin void'(exp_q0.pop_front()); void'(stamp_q0.pop_front()); end
      end
      if (ev1) begin
        chk("rsp1_data", bus.RSP1_DATA, exp_q1[0]);
        if (bus.RSP1_READY) begin void'(exp_q1.pop_front()); void'(stamp_q1.pop_front()); end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_port(input int n, input logic v, input logic [31:0] a, b, input logic [2:0] c);
    if (n == 0) begin
      bus.REQ0_VALID = v; bus.REQ0_A = a; bus.REQ0_B = b; bus.REQ0_CTRL = c;
    end else begin
      bus.REQ1_VALID = v; bus.REQ1_A = a; bus.REQ1_B = b; bus.REQ1_CTRL = c;
    end
  endtask

  task automatic report(input string name, input logic [31:0] got, input logic [31:0] exp);
    @(posedge FPUCLK); #1;
    rep_name = name; rep_got = got; rep_exp = exp; rep_seq++;
    @(posedge FPUCLK); #1;
  endtask

  function automatic logic [2:0] rand_ctrl();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return OP_ADD;
    if (r < 8) return OP_SUB;
    return 3'($urandom_range(2, 7));
  endfunction

  task automatic idle(input int n);
    @(posedge FPUCLK); #1;
    bus.REQ0_VALID = 1'b0;
    bus.REQ1_VALID = 1'b0;
    repeat (n) @(posedge FPUCLK);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge FPUCLK); #1;
    RSTN = 1'b0;
    bus.REQ0_VALID = 1'b0;
    bus.REQ1_VALID = 1'b0;
    repeat (2) @(posedge FPUCLK);
    #1;
    RSTN = 1'b1;
  endtask

  // Present one op on port n and hold it until it is accepted.
  task automatic send1(input int n, input logic [31:0] a, b, input logic [2:0] c);
    logic got;
    got = 1'b0;
    @(posedge FPUCLK); #1;
    set_port(n, 1'b1, a, b, c);
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge FPUCLK);
      got = (n == 0) ? bus.REQ0_READY : bus.REQ1_READY;
    end
    @(posedge FPUCLK); #1;
    set_port(n, 1'b0, a, b, c);
    if (!got) report("send_timeout", 0, 1);
  endtask

  // Random traffic on both ports, holding payload until each op is accepted.
  task automatic run_random(input int cycles, input int v_pct, input int rdy_pct);
    logic a0, a1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge FPUCLK);
      a0 = bus.REQ0_VALID & bus.REQ0_READY;
      a1 = bus.REQ1_VALID & bus.REQ1_READY;
      @(posedge FPUCLK); #1;
      if (!bus.REQ0_VALID || a0)
        set_port(0, $urandom_range(0, 99) < v_pct, $urandom(), $urandom(), rand_ctrl());
      if (!bus.REQ1_VALID || a1)
        set_port(1, $urandom_range(0, 99) < v_pct, $urandom(), $urandom(), rand_ctrl());
      bus.RSP0_READY = $urandom_range(0, 99) < rdy_pct;
      bus.RSP1_READY = $urandom_range(0, 99) < rdy_pct;
    end
  endtask

  // ---------------- stimulus ----------------
  int snap0, snap1;

  initial begin
    set_port(0, 1'b1, 32'h0, 32'h0, OP_ADD);  // valid during reset must not be granted
    set_port(1, 1'b0, 32'h0, 32'h0, OP_ADD);
    bus.RSP0_READY = 1'b1;
    bus.RSP1_READY = 1'b1;
    RSTN = 1'b0;
    repeat (3) @(posedge FPUCLK);
    #1;
    RSTN = 1'b1;
    bus.REQ0_VALID = 1'b0;

    // Single ADD on port 0.
    send1(0, 32'h3F80_0000, 32'h4000_0000, OP_ADD);
    idle(10);

    // Tie: both ports always valid right after reset; port 0 wins first.
    pulse_reset();
    run_random(16, 100, 100);
    idle(12);

    // Credit stall on port 0.
    snap0 = acc0_total;
    bus.RSP0_READY = 1'b0;
    set_port(0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, OP_SUB);
    repeat (12) @(posedge FPUCLK);
    #1;
    report("stall_accepts", acc0_total - snap0, 2);
    bus.RSP0_READY = 1'b1;
    repeat (10) @(posedge FPUCLK);
    idle(12);

    // Unsupported opcode among neighbouring port-1 ops.
    send1(1, 32'h4040_0000, 32'h3F00_0000, OP_ADD);
    send1(1, 32'h4080_0000, 32'h4000_0000, 3'b010);
    send1(1, 32'h40A0_0000, 32'h3F80_0000, OP_SUB);
    idle(12);

    // Random mixed traffic with random response readies.
    run_random(300, 70, 60);
    bus.RSP0_READY = 1'b1;
    bus.RSP1_READY = 1'b1;
    idle(15);

    // Reset with three ops in flight, then confirm full credits on both ports.
    send1(0, $urandom(), $urandom(), OP_ADD);
    send1(1, $urandom(), $urandom(), OP_SUB);
    send1(0, $urandom(), $urandom(), OP_ADD);
    pulse_reset();
    repeat (8) @(posedge FPUCLK);
    #1;
    snap0 = acc0_total;
    snap1 = acc1_total;
    bus.RSP0_READY = 1'b0;
    bus.RSP1_READY = 1'b0;
    set_port(0, 1'b1, 32'h1111_1111, 32'h2222_2222, OP_ADD);
    set_port(1, 1'b1, 32'h3333_3333, 32'h4444_4444, OP_SUB);
    repeat (14) @(posedge FPUCLK);
    #1;
    report("post_reset_credits0", acc0_total - snap0, 2);
    report("post_reset_credits1", acc1_total - snap1, 2);
    bus.RSP0_READY = 1'b1;
    bus.RSP1_READY = 1'b1;
    idle(15);

    repeat (3) @(posedge FPUCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_issue_arb.md
# fpu_issue_arb

Two-port issue arbiter and sequencer for the 4-stage floating-point add/sub pipeline. It accepts operations from two independent requesters over valid/ready handshakes, grants one per cycle round-robin, drives the ALU operand/opcode inputs, and tracks every in-flight op with a tag shift register. Each result is routed back to its originator through a per-requester response FIFO. Issue is credit-gated because the ALU pipeline cannot stall.

## Interface
- LAT, 4: ALU edges from operand capture to result on ALU_OUT (capture edge counts as edge 1)
- RSP_DEPTH, 2: entries per response FIFO; also per-requester credit limit (≥1)
- FPUCLK in 1: clock, all flops rising-edge
- RSTN in 1: reset, asynchronous, active-low
- REQn_VALID in 1 (n=0,1): request valid
- REQn_READY out 1: grant; combinational
- REQn_A, REQn_B in 32: IEEE754 single operands
- REQn_CTRL in 3: opcode
- ALU_A, ALU_B out 32: registered operands to ALU
- ALU_CTRL out 3: registered opcode to ALU
- ALU_OUT in 32: ALU result
- RSPn_VALID out 1: response FIFO non-empty
- RSPn_READY in 1: response consumer ready
- RSPn_DATA out 32: FIFO head

## Operation
- Eligible(n) = REQn_VALID & (credit_n > 0). credit_n starts at RSP_DEPTH. It decrements on accept and increments on RSPn pop; on simultaneous accept and pop it is unchanged.
- Arbitration: one grant per cycle. If both requesters are eligible, grant the one not granted last. The last-grant pointer updates only on a grant and resets to 1, so requester 0 wins the first tie.
- REQn_READY = grant_n. It must not depend on REQn_VALID of the other port beyond the arbitration itself.
- Accept edge k: the issue register loads A, B and CTRL. If CTRL is not ADD (3'b000) or SUB (3'b001), ALU_CTRL gets NOP (3'b111) and the tag is marked "unsupported". With no accept, ALU_CTRL gets NOP and ALU_A/ALU_B hold their values.
- Tag pipe: LAT+1 stages of {valid, id, unsupported}. Stage 0 loads at the accept edge and shifts every cycle unconditionally.
- At the final stage, if valid, push into FIFO[id]: ALU_OUT, or 32'h7FC00000 (quiet NaN) if unsupported.
- Credits guarantee that a push never meets a full FIFO. Push/pop on the same FIFO at the same edge are both performed.
- Results return to each requester in its own issue order. Results across requesters are unordered.

## Timing
- Reset (async assert, sync release): REQn_READY=0 while RSTN low. ALU_A=ALU_B=0, ALU_CTRL=3'b111. RSPn_VALID=0, RSPn_DATA=0. Tag pipe cleared, credits=RSP_DEPTH, pointer=1.
- Accept at edge k → ALU captures at edge k+1 → ALU_OUT valid after edge k+LAT → FIFO push at edge k+LAT+1. RSPn_VALID is high in the cycle after that edge: 5 cycles from accept for LAT=4.
- Throughput: 1 op/cycle total, provided credits are available.
- Reset mid-operation drops all in-flight ops and FIFO contents. No response is produced for them.
- RSPn_DATA is stable while RSPn_VALID & ~RSPn_READY.

## Configuration
- FPU_ARB_STATS_EN defined: adds outputs ISSUE_CNT (16) and STALL_CNT (16). Both reset to 0 and saturate at 16'hFFFF.
  - ISSUE_CNT increments on every accept.
  - STALL_CNT increments on every cycle where some REQn_VALID=1 and no grant is given.
- FPU_ARB_STATS_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared fpu_pkg holds the opcode constants (ADD 3'b000, SUB 3'b001, NOP 3'b111), the QNAN constant 32'h7FC00000, and the tag struct/width.
- One sub-module, fpu_rsp_fifo: parameterised synchronous FIFO with async active-low reset, instantiated twice.

## Test plan
- Single op: REQ0 ADD A=32'h3F800000, B=32'h40000000, accepted at edge k. RSP0_VALID is high in the cycle after edge k+5 with RSP0_DATA = ALU_OUT as sampled after edge k+4. RSP1 never goes valid.
- Tie: both requesters valid on every cycle with credits available. Grants alternate 0,1,0,1. First grant goes to 0 after reset.
- Credit stall: RSP0_READY=0 and REQ0 valid continuously. Exactly 2 accepts occur, then REQ0_READY=0 until the first pop. One accept follows each pop.
- Unsupported: REQ1_CTRL=3'b010. The op is accepted and ALU_CTRL=3'b111 in the issue cycle. RSP1_DATA=32'h7FC00000 at LAT+1 latency, in order with neighbouring REQ1 ops.
- Back-to-back mixed: issue 8 alternating ops with random readies. Every response matches a reference model, per-requester order is preserved, and no FIFO overflows.
- Reset with 3 ops in flight: after RSTN deasserts, there are no RSP valids, credits=2 on both ports, and ALU_CTRL=3'b111.
